// File: rtl/float_pack.sv
// Shared types and constants for the float coprocessor arbiter.
package float_pack;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;

  localparam logic [1:0] COPRO_OP_ADD = 2'b00;
  localparam logic [1:0] COPRO_OP_SUB = 2'b01;
  localparam logic [1:0] COPRO_OP_MUL = 2'b10;
  localparam logic [1:0] COPRO_OP_DIV = 2'b11;

endpackage

// File: rtl/float_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr.
module float_rr_pick
  import float_pack::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  // Walk the requesters starting at rr, wrapping, and keep the first hit.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand     = (32'(rr) + k) % NREQ;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/float_copro_arbiter.sv
// Round-robin arbiter sharing one float_copro between NREQ requesters.
// Optional watchdog abort enabled by defining FLOAT_ARB_WATCHDOG_EN.
module float_copro_arbiter
  import float_pack::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0][10:0] req_opcode,
  input  logic [NREQ-1:0][31:0] req_op0,
  input  logic [NREQ-1:0][31:0] req_op1,
  output logic [NREQ-1:0]       req_complete,
  output logic [NREQ-1:0][31:0] req_result,
  output logic [NREQ-1:0]       req_error,
  output logic                  copro_valid,
  output logic [10:0]           copro_opcode,
  output logic [31:0]           copro_op0,
  output logic [31:0]           copro_op1,
  input  logic                  copro_complete,
  input  logic [31:0]           copro_result
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic                  copro_valid_q, copro_valid_d;
  logic [10:0]           copro_opcode_q, copro_opcode_d;
  logic [31:0]           copro_op0_q, copro_op0_d;
  logic [31:0]           copro_op1_q, copro_op1_d;
  logic [NREQ-1:0]       req_complete_q, req_complete_d;
  logic [NREQ-1:0][31:0] req_result_q, req_result_d;

  logic                  pick_any;
  logic [IW-1:0]         pick_idx;

`ifdef FLOAT_ARB_WATCHDOG_EN
  localparam logic [5:0] WD_LIMIT = 6'(TIMEOUT);
  logic [5:0]            wd_cnt_q, wd_cnt_d;
  logic [NREQ-1:0]       req_error_q, req_error_d;
`else
  logic [5:0]            wd_limit_unused;
  assign wd_limit_unused = 6'(TIMEOUT);
`endif

  float_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid),
    .rr  (rr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and register updates for the IDLE/BUSY/DONE handshake sequencer.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_d           = rr_q;
    copro_valid_d  = copro_valid_q;
    copro_opcode_d = copro_opcode_q;
    copro_op0_d    = copro_op0_q;
    copro_op1_d    = copro_op1_q;
    req_complete_d = req_complete_q;
    req_result_d   = req_result_q;
`ifdef FLOAT_ARB_WATCHDOG_EN
    wd_cnt_d       = wd_cnt_q;
    req_error_d    = req_error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d          = pick_idx;
          copro_opcode_d = req_opcode[pick_idx];
          copro_op0_d    = req_op0[pick_idx];
          copro_op1_d    = req_op1[pick_idx];
          copro_valid_d  = 1'b1;
          state_d        = BUSY;
`ifdef FLOAT_ARB_WATCHDOG_EN
          wd_cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        if (copro_complete) begin
          req_result_d[gnt_q]   = copro_result;
          req_complete_d[gnt_q] = 1'b1;
          copro_valid_d         = 1'b0;
          state_d               = DONE;
        end
`ifdef FLOAT_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_LIMIT) begin
          req_result_d[gnt_q]   = FLOAT_QNAN;
          req_error_d[gnt_q]    = 1'b1;
          req_complete_d[gnt_q] = 1'b1;
          copro_valid_d         = 1'b0;
          state_d               = DONE;
        end else begin
          wd_cnt_d = wd_cnt_q + 6'd1;
        end
`endif
      end
      DONE: begin
        if (!req_valid[gnt_q]) begin
          req_complete_d[gnt_q] = 1'b0;
`ifdef FLOAT_ARB_WATCHDOG_EN
          req_error_d[gnt_q]    = 1'b0;
`endif
          if (gnt_q == IW'(NREQ - 1)) rr_d = '0;
          else                        rr_d = gnt_q + IW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      rr_q           <= '0;
      copro_valid_q  <= 1'b0;
      copro_opcode_q <= '0;
      copro_op0_q    <= '0;
      copro_op1_q    <= '0;
      req_complete_q <= '0;
      req_result_q   <= '0;
`ifdef FLOAT_ARB_WATCHDOG_EN
      wd_cnt_q       <= '0;
      req_error_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_q           <= rr_d;
      copro_valid_q  <= copro_valid_d;
      copro_opcode_q <= copro_opcode_d;
      copro_op0_q    <= copro_op0_d;
      copro_op1_q    <= copro_op1_d;
      req_complete_q <= req_complete_d;
      req_result_q   <= req_result_d;
`ifdef FLOAT_ARB_WATCHDOG_EN
      wd_cnt_q       <= wd_cnt_d;
      req_error_q    <= req_error_d;
`endif
    end
  end

  assign copro_valid  = copro_valid_q;
  assign copro_opcode = copro_opcode_q;
  assign copro_op0    = copro_op0_q;
  assign copro_op1    = copro_op1_q;
  assign req_complete = req_complete_q;
  assign req_result   = req_result_q;
`ifdef FLOAT_ARB_WATCHDOG_EN
  assign req_error    = req_error_q;
`else
  assign req_error    = '0;
`endif

endmodule
